// File: rtl/simplecpu_pkg.sv
// simplecpu_pkg: shared definitions for the program loader.
//   - default program depth / word width
//   - bit positions of the logic-analyzer command word fields
//   - loader state encoding (visible on status_o[1:0])
package simplecpu_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int DW_DEF    = 8;

  // la_cmd_i field positions
  localparam int CMD_W    = 16;
  localparam int DATA_LSB = 0;   // [7:0]   program word
  localparam int ADDR_LSB = 8;   // [11:8]  program address
  localparam int WR_BIT   = 12;  // write toggle: any edge is one write
  localparam int RUN_BIT  = 13;  // run level
  localparam int CLR_BIT  = 14;  // clear level
  localparam int RSV_BIT  = 15;  // reserved, ignored

  // Control bits crossing into the clock domain, contiguous from WR_BIT
  localparam int CTL_N = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for one asynchronous level.
//   clk_i  sampling clock
//   rst_i  synchronous active-high reset, clears both flops
//   d_i    asynchronous input
//   q_o    synchronized output (two clk_i edges of latency)
module sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/prog_loader.sv
// prog_loader: loads a flop-based program memory from a logic-analyzer
// command word and holds the downstream CPU in reset until told to run.
//   wb_clk_i     clock
//   wb_rst_i     synchronous active-high reset
//   la_cmd_i     [7:0] data, [11:8] addr, [12] write toggle, [13] run, [14] clear
//   cpu_pc_i     CPU fetch address
//   cpu_instr_o  mem[cpu_pc_i], registered (read-before-write on collision)
//   cpu_rst_o    registered CPU hold-in-reset, low only in RUN
//   status_o     [1:0] state, [2] error, [7:3] write count (saturates at DEPTH)
module prog_loader
  import simplecpu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [CMD_W-1:0]         la_cmd_i,
  input  logic [$clog2(DEPTH)-1:0] cpu_pc_i,
  output logic [DW-1:0]            cpu_instr_o,
  output logic                     cpu_rst_o,
  output logic [7:0]               status_o
);

  localparam int AW = $clog2(DEPTH);

  // ---------------------------------------------------------------
  // Control bit synchronization and edge detection
  // ---------------------------------------------------------------
  logic [CTL_N-1:0] ctl_sync;  // [0] write, [1] run, [2] clear
  logic [CTL_N-1:0] hist_q;

  for (genvar gi = 0; gi < CTL_N; gi++) begin : g_sync
    sync2 u_sync (
      .clk_i (wb_clk_i),
      .rst_i (wb_rst_i),
      .d_i   (la_cmd_i[WR_BIT+gi]),
      .q_o   (ctl_sync[gi])
    );
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) hist_q <= '0;
    else          hist_q <= ctl_sync;
  end

  logic wr_ev, run_rise, run_fall, clr_rise;
  assign wr_ev    = ctl_sync[0] ^ hist_q[0];
  assign run_rise = ctl_sync[1] & ~hist_q[1];
  assign run_fall = ~ctl_sync[1] & hist_q[1];
  assign clr_rise = ctl_sync[2] & ~hist_q[2];

  // Data and address are not synchronized: the host holds them stable
  // across the whole toggle-to-commit window, so sampling them raw at the
  // commit edge is safe.
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  assign wr_addr = la_cmd_i[ADDR_LSB +: AW];
  assign wr_data = la_cmd_i[DATA_LSB +: DW];

  logic unused_rsv;
  assign unused_rsv = la_cmd_i[RSV_BIT];

  // ---------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------
  state_e state_q, state_d;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Clear beats everything; in IDLE/LOAD a coincident write still lands
  // before moving to RUN; a write while running is a protocol error.
  always_comb begin
    state_d = state_q;
    if (clr_rise) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_LOAD: begin
          if (run_rise)   state_d = ST_RUN;
          else if (wr_ev) state_d = ST_LOAD;
        end
        ST_RUN: begin
          if (wr_ev)         state_d = ST_ERR;
          else if (run_fall) state_d = ST_IDLE;
        end
        ST_ERR:  state_d = ST_ERR;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  logic       mem_we;
  logic [4:0] count_q, count_d;
  logic       cpu_rst_q, cpu_rst_d;

  always_comb begin
    mem_we    = 1'b0;
    count_d   = count_q;
    cpu_rst_d = (state_d != ST_RUN);
    if (clr_rise) begin
      count_d = '0;
    end else if (wr_ev && (state_q == ST_IDLE || state_q == ST_LOAD)) begin
      mem_we = 1'b1;
      // Writes keep landing at saturation; only the counter stops.
      if (count_q != 5'(DEPTH)) count_d = count_q + 5'd1;
    end
  end

  // ---------------------------------------------------------------
  // Datapath: counter, program memory, fetch port
  // ---------------------------------------------------------------
  logic [DEPTH-1:0][DW-1:0] mem_q;
  logic [DW-1:0]            instr_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      count_q   <= '0;
      cpu_rst_q <= 1'b1;
      mem_q     <= '0;
      instr_q   <= '0;
    end else begin
      count_q   <= count_d;
      cpu_rst_q <= cpu_rst_d;
      // Fetch reads the pre-write contents on a same-address collision.
      instr_q   <= mem_q[cpu_pc_i];
      if (clr_rise)    mem_q          <= '0;
      else if (mem_we) mem_q[wr_addr] <= wr_data;
    end
  end

  assign cpu_instr_o = instr_q;
  assign cpu_rst_o   = cpu_rst_q;
  assign status_o    = {count_q, (state_q == ST_ERR), state_q};

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cmd = '0;
  logic [3:0]  pc  = '0;
  logic [7:0]  instr;
  logic        crst;
  logic [7:0]  status;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prog_loader dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .la_cmd_i    (cmd),
    .cpu_pc_i    (pc),
    .cpu_instr_o (instr),
    .cpu_rst_o   (crst),
    .status_o    (status)
  );

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Control pins reach the loader through a 3-deep delay line; an edge
  // takes effect when it reaches the end of the line.
  logic [2:0] dl1, dl2, dl3;
  logic [7:0] m_mem [16];
  int         m_st;    // 0 idle, 1 load, 2 run, 3 err
  int         m_cnt;
  logic [7:0] m_instr;
  logic       m_rst;
  bit         m_valid = 0;

  function automatic logic [7:0] m_status();
    logic [4:0] c;
    logic [1:0] s;
    c = 5'(m_cnt);
    s = 2'(m_st);
    return {c, (m_st == 3), s};
  endfunction

  task automatic model_step();
    bit wr, rr, rf, cr;
    if (rst) begin
      dl1 = '0; dl2 = '0; dl3 = '0;
      m_st = 0; m_cnt = 0; m_instr = '0; m_rst = 1'b1;
      for (int i = 0; i < 16; i++) m_mem[i] = '0;
      m_valid = 1;
    end else begin
      wr = dl2[0] != dl3[0];
      rr = dl2[1] && !dl3[1];
      rf = !dl2[1] && dl3[1];
      cr = dl2[2] && !dl3[2];
      m_instr = m_mem[pc];
      if (cr) begin
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        m_cnt = 0; m_st = 0;
      end else if (m_st <= 1) begin
        if (wr) begin
          m_mem[cmd[11:8]] = cmd[7:0];
          if (m_cnt < 16) m_cnt++;
          m_st = 1;
        end
        if (rr) m_st = 2;
      end else if (m_st == 2) begin
        if (wr) m_st = 3;
        else if (rf) m_st = 0;
      end
      m_rst = (m_st != 2);
      dl3 = dl2; dl2 = dl1; dl1 = cmd[14:12];
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("model_status", status, m_status());
      check("model_cpu_rst", {7'd0, crst}, {7'd0, m_rst});
      check("model_instr", instr, m_instr);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    cmd[11:8] = a; cmd[7:0] = d; cmd[12] = ~cmd[12];
    repeat (3) @(negedge clk);
  endtask

  task automatic set_lvl(input int b, input logic v);
    @(negedge clk);
    cmd[b] = v;
    repeat (3) @(negedge clk);
  endtask

  task automatic fetch(input logic [3:0] a);
    @(negedge clk);
    pc = a;
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (2) @(negedge clk);
    check("reset_status", status, 8'h00);
    check("reset_cpu_rst", {7'd0, crst}, 8'h01);
    check("reset_instr", instr, 8'h00);
    rst = 1'b0;

    // first write, then fetch it
    do_write(4'd3, 8'hA5);
    check("w1_status", status, 8'h09);
    check("w1_cpu_rst", {7'd0, crst}, 8'h01);
    fetch(4'd3);
    check("w1_fetch", instr, 8'hA5);

    // clear pulse
    set_lvl(14, 1'b1);
    check("clr_status", status, 8'h00);
    @(negedge clk);
    check("clr_fetch", instr, 8'h00);
    set_lvl(14, 1'b0);

    // 17 writes, counter saturates, last overwrites addr 0
    for (int i = 0; i < 16; i++) do_write(4'(i), 8'h10 + 8'(i));
    do_write(4'd0, 8'h77);
    check("sat_status", status, 8'h81);
    fetch(4'd0);
    check("sat_mem0", instr, 8'h77);
    fetch(4'd15);
    check("sat_mem15", instr, 8'h1F);

    // run: cpu_rst falls on the third edge after the pin change
    @(negedge clk); cmd[13] = 1'b1;
    @(negedge clk); check("run_e0", {7'd0, crst}, 8'h01);
    @(negedge clk); check("run_e1", {7'd0, crst}, 8'h01);
    @(negedge clk); check("run_e2", {7'd0, crst}, 8'h00);
    check("run_status", status, 8'h82);
    set_lvl(13, 1'b0);
    check("stop_status", status, 8'h80);
    check("stop_cpu_rst", {7'd0, crst}, 8'h01);

    // write while running -> error, write dropped
    set_lvl(13, 1'b1);
    check("run2_status", status, 8'h82);
    do_write(4'd5, 8'hFF);
    check("err_status", status, 8'h87);
    check("err_cpu_rst", {7'd0, crst}, 8'h01);
    fetch(4'd5);
    check("err_mem5", instr, 8'h15);
    set_lvl(13, 1'b0);
    set_lvl(13, 1'b1);
    check("err_sticky", status, 8'h87);
    set_lvl(14, 1'b1);
    check("err_clr_status", status, 8'h00);
    @(negedge clk);
    check("err_clr_mem5", instr, 8'h00);
    @(negedge clk); cmd[14] = 1'b0; cmd[13] = 1'b0;
    repeat (3) @(negedge clk);
    check("falls_ignored", status, 8'h00);

    // clear coincident with write
    do_write(4'd2, 8'h33);
    check("pre_clr_status", status, 8'h09);
    @(negedge clk);
    cmd[11:8] = 4'd4; cmd[7:0] = 8'h44; cmd[12] = ~cmd[12]; cmd[14] = 1'b1;
    repeat (3) @(negedge clk);
    check("clr_wr_status", status, 8'h00);
    fetch(4'd4);
    check("clr_wr_mem4", instr, 8'h00);
    fetch(4'd2);
    check("clr_wr_mem2", instr, 8'h00);
    set_lvl(14, 1'b0);

    // reset mid-load discards the pending toggle (pin back to 0)
    @(negedge clk);
    cmd[11:8] = 4'd1; cmd[7:0] = 8'h11; cmd[12] = ~cmd[12];
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("midrst_status", status, 8'h00);
    check("midrst_cpu_rst", {7'd0, crst}, 8'h01);
    check("midrst_instr", instr, 8'h00);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_discard", status, 8'h00);

    // toggle bit high across reset -> exactly one write afterwards
    @(negedge clk);
    cmd[11:8] = 4'd6; cmd[7:0] = 8'h66; cmd[12] = ~cmd[12]; rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_write", status, 8'h09);
    fetch(4'd6);
    check("post_rst_mem6", instr, 8'h66);

    // same-cycle read/write collision
    fetch(4'd7);
    do_write(4'd7, 8'h77);
    check("coll_old", instr, 8'h00);
    @(negedge clk);
    check("coll_new", instr, 8'h77);
    check("coll_status", status, 8'h11);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
